// File: rtl/player_input_mapped.sv
`timescale 1ns/1ps
// player_input_mapped: synchronises the keyboard byte stream, parses set-2 make/break/E0 prefixes and tracks held keys from KEYMAP.
// Define PLAYER_INPUT_OVERRUN_CLEAR_EN to release all keys on AA/00/FF received in IDLE.
module player_input_mapped #(
   parameter int NUM_PLAYERS = 2,
   parameter int KEYS_PER_PLAYER = 5,
   parameter logic [NUM_PLAYERS*KEYS_PER_PLAYER*9-1:0] KEYMAP =
      {9'h043, 9'h03B, 9'h042, 9'h04B, 9'h044, 9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h024},
   parameter int PREFIX_TIMEOUT = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic [7:0] code_byte,
   input  logic code_flag,
   output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] key_held,
   output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] key_pressed,
   output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] key_released,
   output logic parse_error
);
   localparam int N = NUM_PLAYERS * KEYS_PER_PLAYER;
   localparam int CW = $clog2(PREFIX_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
   state_t state, state_next;
   logic s1, s2, s3, strobe, ext, err_next;
   logic [2:0] skip_cnt, skip_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [N-1:0] held, held_next, match;
   assign strobe = s2 & ~s3;
   assign ext = (state == EXT) || (state == EXT_BRK);
   assign key_held = held;
   for (genvar i = 0; i < N; i++) begin : g_match
      assign match[i] = KEYMAP[i*9 +: 9] == {ext, code_byte};
   end
   always_comb begin
      state_next = state;
      skip_next = skip_cnt;
      cnt_next = cnt;
      held_next = held;
      err_next = 1'b0;
      if (strobe) begin
         cnt_next = '0;
         case (state)
            IDLE: begin
               if (code_byte == 8'hE0) state_next = EXT;
               else if (code_byte == 8'hF0) state_next = BRK;
               else if (code_byte == 8'hE1) begin
                  state_next = SKIP;
                  skip_next = 3'd7;
               end
`ifdef PLAYER_INPUT_OVERRUN_CLEAR_EN
               else if (code_byte inside {8'hAA, 8'h00, 8'hFF}) held_next = '0;
`endif
               else if (!(code_byte inside {8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF})) held_next = held | match;
            end
            EXT: begin
               if (code_byte == 8'hF0) state_next = EXT_BRK;
               else if (code_byte != 8'hE0) begin
                  held_next = held | match;
                  state_next = IDLE;
               end
            end
            BRK: begin
               if (code_byte != 8'hF0) begin
                  held_next = held & ~match;
                  state_next = IDLE;
               end
            end
            EXT_BRK: begin
               held_next = held & ~match;
               state_next = IDLE;
            end
            SKIP: begin
               skip_next = skip_cnt - 3'd1;
               state_next = skip_cnt == 3'd1 ? IDLE : SKIP;
            end
            default: state_next = IDLE;
         endcase
      end else if (state != IDLE) begin
         // a stalled prefix is dropped so the next byte starts clean
         if (cnt == CW'(PREFIX_TIMEOUT - 1)) begin
            state_next = IDLE;
            cnt_next = '0;
            err_next = 1'b1;
         end else cnt_next = cnt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {s1, s2, s3} <= '0;
         state <= IDLE;
         skip_cnt <= '0;
         cnt <= '0;
         held <= '0;
         key_pressed <= '0;
         key_released <= '0;
         parse_error <= 1'b0;
      end else begin
         {s1, s2, s3} <= {code_flag, s1, s2};
         state <= state_next;
         skip_cnt <= skip_next;
         cnt <= cnt_next;
         held <= held_next;
         key_pressed <= held_next & ~held;
         key_released <= ~held_next & held;
         parse_error <= err_next;
      end
   end
endmodule

// File: tb/tb_player_input_mapped.sv
`timescale 1ns/1ps
// tb_player_input_mapped: table-driven byte stream with a scoreboard queue, plus timeout and reset sequences.
module tb_player_input_mapped;
   localparam logic [89:0] KM2 = {9'h043, 9'h03B, 9'h042, 9'h04B, 9'h044, 9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h175};
   localparam logic [9:0] K0 = 10'h001, K4 = 10'h010, K9 = 10'h200, Z = 10'h000;
`ifdef PLAYER_INPUT_OVERRUN_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif
   typedef struct {
      logic [7:0] b;
      logic [9:0] h, p, r, h2;
   } vec_t;
   logic clk = 0, rst = 1, code_flag = 0;
   logic [7:0] code_byte = 0;
   logic [9:0] key_held, key_pressed, key_released, held2, pr2, rl2;
   logic parse_error, pe2;
   int total = 0, bad = 0;
   logic [9:0] cur_h = 0;
   vec_t tbl[$];
   vec_t sb[$];
   player_input_mapped #(.PREFIX_TIMEOUT(20)) dut (
      .clk(clk), .rst(rst), .code_byte(code_byte), .code_flag(code_flag),
      .key_held(key_held), .key_pressed(key_pressed), .key_released(key_released), .parse_error(parse_error));
   player_input_mapped #(.KEYMAP(KM2), .PREFIX_TIMEOUT(20)) dut2 (
      .clk(clk), .rst(rst), .code_byte(code_byte), .code_flag(code_flag),
      .key_held(held2), .key_pressed(pr2), .key_released(rl2), .parse_error(pe2));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, a, e);
      end
   endtask
   function automatic void add(input logic [7:0] b, input logic [9:0] h, p, r, h2);
      vec_t v;
      v.b = b; v.h = h; v.p = p; v.r = r; v.h2 = h2;
      tbl.push_back(v);
   endfunction
   task automatic send(input vec_t e);
      vec_t x;
      sb.push_back(e);
      @(negedge clk);
      code_byte = e.b;
      code_flag = 1;
      @(posedge clk);
      @(posedge clk); #1;
      chk("latency_held", 32'(key_held), 32'(cur_h));
      chk("latency_pressed", 32'(key_pressed), 0);
      @(posedge clk); #1;
      x = sb.pop_front();
      chk("held", 32'(key_held), 32'(x.h));
      chk("pressed", 32'(key_pressed), 32'(x.p));
      chk("released", 32'(key_released), 32'(x.r));
      chk("held_extmap", 32'(held2), 32'(x.h2));
      cur_h = x.h;
      @(posedge clk); #1;
      chk("pulse_width", 32'(key_pressed | key_released), 0);
      chk("no_parse_error", 32'(parse_error), 0);
      code_flag = 0;
      repeat (3) @(posedge clk);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      chk("reset_held", 32'(key_held), 0);
      chk("reset_held_extmap", 32'(held2), 0);
      @(posedge clk); #1;
      chk("reset_no_pulse", 32'({key_pressed, key_released, parse_error}), 0);
      cur_h = 0;
   endtask
   function automatic vec_t v1(input logic [7:0] b, input logic [9:0] h, p, r, h2);
      vec_t v;
      v.b = b; v.h = h; v.p = p; v.r = r; v.h2 = h2;
      return v;
   endfunction
   initial begin
      int pulses;
      add(8'h1D, K4, K4, Z, K4);
      add(8'h1D, K4, Z, Z, K4);
      add(8'h1D, K4, Z, Z, K4);
      add(8'hF0, K4, Z, Z, K4);
      add(8'h1D, Z, Z, K4, Z);
      add(8'hF0, Z, Z, Z, Z);
      add(8'h1D, Z, Z, Z, Z);
      add(8'hE0, Z, Z, Z, Z);
      add(8'h75, Z, Z, Z, K0);
      add(8'h75, Z, Z, Z, K0);
      add(8'hE0, Z, Z, Z, K0);
      add(8'hF0, Z, Z, Z, K0);
      add(8'h75, Z, Z, Z, Z);
      add(8'h43, K9, K9, Z, K9);
      add(8'hE1, K9, Z, Z, K9);
      add(8'h14, K9, Z, Z, K9);
      add(8'h77, K9, Z, Z, K9);
      add(8'hE1, K9, Z, Z, K9);
      add(8'hF0, K9, Z, Z, K9);
      add(8'h14, K9, Z, Z, K9);
      add(8'hF0, K9, Z, Z, K9);
      add(8'h77, K9, Z, Z, K9);
      add(8'h1D, K9 | K4, K4, Z, K9 | K4);
      add(8'hAA, CLR ? Z : K9 | K4, Z, CLR ? K9 | K4 : Z, CLR ? Z : K9 | K4);
      do_reset();
      for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
      do_reset();
      send(v1(8'hE0, Z, Z, Z, Z));
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (parse_error) pulses++;
      end
      chk("timeout_pulses", 32'(pulses), 1);
      send(v1(8'h43, K9, K9, Z, K9));
      send(v1(8'hE0, K9, Z, Z, K9));
      do_reset();
      send(v1(8'h75, Z, Z, Z, Z));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end
endmodule
